weight_emergency_ctrl: RTL and testbench
========================================

WEIGHT_EMERGENCY_CTRL -- requirements
Module: weight_emergency_ctrl

Interface
REQ-001 Parameter CLEAR_CYCLES, 8: consecutive synchronised load_cleared cycles required before reset.
REQ-002 Parameter PULSE_CYCLES, 2: weight_flip_reset pulse width, in cycles.
REQ-003 Parameter REARM_TIMEOUT, 16: cycles to wait for weight_limit_exceeded to fall after the pulse.
REQ-004 Parameter MAX_EVENTS, 3: overload entries that force lockout; event_count width is 4 bits.
REQ-005 clk  input  1  single system clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 weight_limit_exceeded  input  1  overload flag from the weight_control block; asynchronous to clk.
REQ-008 load_cleared  input  1  load sensor reports below threshold; asynchronous to clk.
REQ-009 maint_clear  input  1  synchronous single-cycle maintenance acknowledge.
REQ-010 weight_flip_reset  output  1  reset pulse to the weight_control block.
REQ-011 door_hold  output  1  keeps the doors open.
REQ-012 motion_inhibit  output  1  blocks new travel commands.
REQ-013 alarm  output  1  drives the overload buzzer and indicator.
REQ-014 lockout  output  1  car is out of service pending maintenance.
REQ-015 event_count  output  4  overload entries since the last clear.

Function
REQ-016 weight_limit_exceeded and load_cleared SHALL each pass a 2-flop synchroniser (exc_s, clr_s) before any use.
REQ-017 All outputs SHALL be registered and SHALL change on the same edge the state register enters the new state.
REQ-018 States SHALL be IDLE, OVERLOAD, CLEAR_WAIT, RESET_PULSE, REARM and LOCKOUT.
REQ-019 IDLE: all outputs 0; exc_s=1 -> OVERLOAD, so the outputs rise 3 edges after the input rises.
REQ-020 On every entry into OVERLOAD, event_count SHALL increment, saturating at 15.
REQ-021 If the incremented event_count equals MAX_EVENTS, the FSM SHALL go to LOCKOUT instead of OVERLOAD.
REQ-022 OVERLOAD: door_hold=1, motion_inhibit=1, alarm=1; clr_s=1 -> CLEAR_WAIT.
REQ-023 CLEAR_WAIT: outputs as OVERLOAD; a counter counts consecutive clr_s=1 cycles.
REQ-024 In CLEAR_WAIT, clr_s=0 SHALL return to OVERLOAD with no event_count increment.
REQ-025 In CLEAR_WAIT, when the count reaches CLEAR_CYCLES the FSM SHALL go to RESET_PULSE.
REQ-026 RESET_PULSE: weight_flip_reset=1 for exactly PULSE_CYCLES cycles, alarm=0, door_hold=1, motion_inhibit=1; then REARM.
REQ-027 REARM: weight_flip_reset=0, door_hold=1, motion_inhibit=1.
REQ-028 In REARM, exc_s=0 -> IDLE.
REQ-029 If exc_s is still 1 after REARM_TIMEOUT cycles, the FSM SHALL re-enter OVERLOAD, counted as a new event.
REQ-030 LOCKOUT: door_hold=1, motion_inhibit=1, alarm=1, lockout=1.
REQ-031 LOCKOUT SHALL exit to IDLE only on maint_clear=1 with exc_s=0, clearing event_count.
REQ-032 In LOCKOUT, maint_clear=1 with exc_s=1 SHALL be ignored.
REQ-033 maint_clear in IDLE SHALL clear event_count; in OVERLOAD, CLEAR_WAIT, RESET_PULSE and REARM it SHALL be ignored.
REQ-034 Each internal counter SHALL reload to 0 on every entry into its state.

Reset
REQ-035 rst_n=0 SHALL immediately force state IDLE, clear all outputs, counters and synchroniser flops, and event_count to 0.
REQ-036 Reset asserted mid-pulse SHALL drop weight_flip_reset asynchronously.
REQ-037 After rst_n rises, the first state transition SHALL be possible no earlier than the third clk edge.

Structure
REQ-038 State encodings and default parameter values SHALL live in a shared emergency include file used by the other emergency blocks.
REQ-039 The synchroniser SHALL be a separate sub-module, sync_2ff, instantiated twice.
REQ-040 The FSM, counters and output registers SHALL live in weight_emergency_ctrl.

Verification
REQ-041 Raise exceeded, raise cleared 20 cycles later, drop exceeded during the pulse -> alarm for ≥20 cycles, 2-cycle weight_flip_reset after 8 clear cycles, IDLE, event_count=1.
REQ-042 Toggle cleared 1/0 every 4 cycles while exceeded -> no weight_flip_reset, CLEAR_WAIT<->OVERLOAD, event_count stays 1.
REQ-043 Hold exceeded high through REARM -> OVERLOAD after 16 cycles, event_count=2, then 3 -> lockout=1.
REQ-044 In LOCKOUT: maint_clear with exceeded=1 -> stays LOCKOUT; with exceeded=0 -> IDLE, event_count=0.
REQ-045 Assert rst_n=0 mid RESET_PULSE -> weight_flip_reset=0 before the next edge, all outputs 0.

Source files
------------

// File: rtl/weight_emergency_ctrl_pkg.sv
// Shared definitions for the emergency blocks: FSM state encoding, default
// timing parameters, the output bundle and the small helpers that go with it.
package weight_emergency_ctrl_pkg;

    localparam int DEF_CLEAR_CYCLES  = 8;
    localparam int DEF_PULSE_CYCLES  = 2;
    localparam int DEF_REARM_TIMEOUT = 16;
    localparam int DEF_MAX_EVENTS    = 3;

    localparam int EVENT_W = 4;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OVERLOAD,
        ST_CLEAR_WAIT,
        ST_RESET_PULSE,
        ST_REARM,
        ST_LOCKOUT
    } emg_state_t;

    typedef struct packed {
        logic weight_flip_reset;
        logic door_hold;
        logic motion_inhibit;
        logic alarm;
        logic lockout;
    } emg_out_t;

    // Output pattern that belongs to a state; registered against the next
    // state so outputs switch on the same edge as the state register.
    function automatic emg_out_t state_outputs(input emg_state_t s);
        emg_out_t o;
        o = '0;
        unique case (s)
            ST_IDLE:        o = '0;
            ST_OVERLOAD,
            ST_CLEAR_WAIT:  begin o.door_hold = 1'b1; o.motion_inhibit = 1'b1; o.alarm = 1'b1; end
            ST_RESET_PULSE: begin o.weight_flip_reset = 1'b1; o.door_hold = 1'b1; o.motion_inhibit = 1'b1; end
            ST_REARM:       begin o.door_hold = 1'b1; o.motion_inhibit = 1'b1; end
            ST_LOCKOUT:     begin o.door_hold = 1'b1; o.motion_inhibit = 1'b1; o.alarm = 1'b1; o.lockout = 1'b1; end
            default:        o = '0;
        endcase
        return o;
    endfunction

    // Saturating increment for the overload event counter.
    function automatic logic [EVENT_W-1:0] sat_inc(input logic [EVENT_W-1:0] v);
        return (v == {EVENT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/weight_emergency_ctrl.sv
// Overload emergency controller: latches an overload from the weight block,
// waits for the load to stay cleared, pulses a reset back to the weight block,
// rearms, and locks the car out after repeated overloads.
// Ports: clk, rst_n (async active-low); weight_limit_exceeded, load_cleared
// (async levels); maint_clear (sync pulse); weight_flip_reset, door_hold,
// motion_inhibit, alarm, lockout (registered); event_count[3:0].
module weight_emergency_ctrl
    import weight_emergency_ctrl_pkg::*;
#(
    parameter int CLEAR_CYCLES  = DEF_CLEAR_CYCLES,
    parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
    parameter int REARM_TIMEOUT = DEF_REARM_TIMEOUT,
    parameter int MAX_EVENTS    = DEF_MAX_EVENTS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               weight_limit_exceeded,
    input  logic               load_cleared,
    input  logic               maint_clear,
    output logic               weight_flip_reset,
    output logic               door_hold,
    output logic               motion_inhibit,
    output logic               alarm,
    output logic               lockout,
    output logic [EVENT_W-1:0] event_count
);

    localparam logic [CNT_W-1:0]   CLR_LAST   = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REARM_LAST = CNT_W'(REARM_TIMEOUT - 1);
    localparam logic [EVENT_W-1:0] MAX_EVT    = EVENT_W'(MAX_EVENTS);

    logic exc_s, clr_s;

    sync_2ff u_sync_exc (.clk(clk), .rst_n(rst_n), .d(weight_limit_exceeded), .q(exc_s));
    sync_2ff u_sync_clr (.clk(clk), .rst_n(rst_n), .d(load_cleared),          .q(clr_s));

    emg_state_t         state, nxt_state;
    logic [CNT_W-1:0]   cnt;
    logic [EVENT_W-1:0] nxt_events;
    emg_out_t           outs;

    always_comb begin
        nxt_state  = state;
        nxt_events = event_count;
        unique case (state)
            ST_IDLE: begin
                // A maintenance clear in the same cycle as a new overload
                // clears first, so the new overload counts as event 1.
                if (maint_clear) nxt_events = '0;
                if (exc_s) begin
                    nxt_events = sat_inc(nxt_events);
                    nxt_state  = (nxt_events == MAX_EVT) ? ST_LOCKOUT : ST_OVERLOAD;
                end
            end
            ST_OVERLOAD:
                if (clr_s) nxt_state = ST_CLEAR_WAIT;
            ST_CLEAR_WAIT: begin
                // Going back to OVERLOAD here is not a new event.
                if (!clr_s)                nxt_state = ST_OVERLOAD;
                else if (cnt == CLR_LAST)  nxt_state = ST_RESET_PULSE;
            end
            ST_RESET_PULSE:
                if (cnt == PULSE_LAST) nxt_state = ST_REARM;
            ST_REARM: begin
                if (!exc_s) begin
                    nxt_state = ST_IDLE;
                end else if (cnt == REARM_LAST) begin
                    nxt_events = sat_inc(event_count);
                    nxt_state  = (nxt_events == MAX_EVT) ? ST_LOCKOUT : ST_OVERLOAD;
                end
            end
            ST_LOCKOUT: begin
                if (maint_clear && !exc_s) begin
                    nxt_state  = ST_IDLE;
                    nxt_events = '0;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            event_count <= '0;
            outs        <= '0;
        end else begin
            state       <= nxt_state;
            event_count <= nxt_events;
            outs        <= state_outputs(nxt_state);
            // Single shared counter: reloads on any state change, and only
            // advances in the states that time something.
            if (nxt_state != state)
                cnt <= '0;
            else if (state inside {ST_CLEAR_WAIT, ST_RESET_PULSE, ST_REARM})
                cnt <= cnt + 1'b1;
        end
    end

    assign weight_flip_reset = outs.weight_flip_reset;
    assign door_hold         = outs.door_hold;
    assign motion_inhibit    = outs.motion_inhibit;
    assign alarm             = outs.alarm;
    assign lockout           = outs.lockout;

endmodule

// File: tb/tb_weight_emergency_ctrl.sv
// Self-checking bench for weight_emergency_ctrl: directed scenarios followed
// by random input activity, every cycle compared against a behavioural model.
module tb_weight_emergency_ctrl;

    localparam int CLEAR_CYCLES  = 8;
    localparam int PULSE_CYCLES  = 2;
    localparam int REARM_TIMEOUT = 16;
    localparam int MAX_EVENTS    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       exc = 1'b0, clr = 1'b0, mc = 1'b0;
    logic       wfr, door, motion, alarm, lock;
    logic [3:0] evc;

    int total = 0;
    int bad   = 0;
    int wfr_cycles = 0, alarm_cycles = 0;

    always #5 clk = ~clk;

    weight_emergency_ctrl #(
        .CLEAR_CYCLES(CLEAR_CYCLES), .PULSE_CYCLES(PULSE_CYCLES),
        .REARM_TIMEOUT(REARM_TIMEOUT), .MAX_EVENTS(MAX_EVENTS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .weight_limit_exceeded(exc), .load_cleared(clr), .maint_clear(mc),
        .weight_flip_reset(wfr), .door_hold(door), .motion_inhibit(motion),
        .alarm(alarm), .lockout(lock), .event_count(evc)
    );

    // Behavioural model: activity flags and countdowns rather than a state
    // variable. ex1/ex2, cl1/cl2 are the two-cycle input delay.
    bit ex1, ex2, cl1, cl2;
    int events;
    bit locked, alarm_on, in_clear;
    int clr_run, pulse_left, rearm_t;

    task automatic model_reset();
        ex1 = 0; ex2 = 0; cl1 = 0; cl2 = 0;
        events = 0; locked = 0; alarm_on = 0; in_clear = 0;
        clr_run = 0; pulse_left = 0; rearm_t = -1;
    endtask

    task automatic new_event();
        events = (events < 15) ? events + 1 : 15;
        if (events == MAX_EVENTS) locked = 1;
        else                      alarm_on = 1;
    endtask

    task automatic model_edge(input bit m);
        bit es, cs;
        es = ex2; cs = cl2;
        ex2 = ex1; ex1 = exc;
        cl2 = cl1; cl1 = clr;
        if (locked) begin
            if (m && !es) begin locked = 0; events = 0; end
        end else if (pulse_left > 0) begin
            pulse_left--;
            if (pulse_left == 0) rearm_t = 0;
        end else if (rearm_t >= 0) begin
            if (!es)                               rearm_t = -1;
            else if (rearm_t == REARM_TIMEOUT - 1) begin rearm_t = -1; new_event(); end
            else                                   rearm_t++;
        end else if (alarm_on) begin
            if (!in_clear) begin
                if (cs) begin in_clear = 1; clr_run = 0; end
            end else if (!cs) begin
                in_clear = 0;
            end else if (clr_run == CLEAR_CYCLES - 1) begin
                alarm_on = 0; in_clear = 0; pulse_left = PULSE_CYCLES;
            end else begin
                clr_run++;
            end
        end else begin
            if (m)  events = 0;
            if (es) new_event();
        end
    endtask

    function automatic logic [8:0] model_out();
        logic busy;
        busy = locked || alarm_on || (pulse_left > 0) || (rearm_t >= 0);
        return {logic'(pulse_left > 0), busy, busy, logic'(locked || alarm_on),
                logic'(locked), 4'(events)};
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_edge(mc);
            @(negedge clk);
            check(tag, {wfr, door, motion, alarm, lock, evc}, model_out());
            if (wfr)   wfr_cycles++;
            if (alarm) alarm_cycles++;
        end
    endtask

    task automatic wait_pulse(input string tag);
        int k;
        k = 0;
        while (wfr !== 1'b1 && k < 100) begin step(1, tag); k++; end
        check({tag, "_timeout"}, {8'h0, wfr}, 9'h1);
    endtask

    initial begin
        model_reset();
        #1;
        check("reset_state", {wfr, door, motion, alarm, lock, evc}, 9'h0);
        step(2, "in_reset");
        rst_n = 1'b1;

        // Overload, clear after 20 cycles, drop overload during the pulse.
        alarm_cycles = 0; wfr_cycles = 0;
        exc = 1'b1;
        step(20, "ovl_hold");
        clr = 1'b1;
        wait_pulse("pulse1");
        exc = 1'b0;
        step(30, "rearm_idle");
        check("pulse_width", 9'(wfr_cycles), 9'(PULSE_CYCLES));
        check("alarm_ge20", {8'h0, logic'(alarm_cycles >= 20)}, 9'h1);
        check("evc_after_1", {5'h0, evc}, 9'h1);
        check("idle_after_1", {wfr, door, motion, alarm, lock, 4'h0}, 9'h0);

        // Maintenance clear in idle, then clear toggling too fast to finish.
        clr = 1'b0; mc = 1'b1;
        step(1, "mc_idle");
        mc = 1'b0;
        check("evc_cleared", {5'h0, evc}, 9'h0);
        exc = 1'b1;
        step(4, "ovl2");
        wfr_cycles = 0;
        for (int r = 0; r < 5; r++) begin
            clr = 1'b1; step(4, "toggle_hi");
            clr = 1'b0; step(4, "toggle_lo");
        end
        check("toggle_no_pulse", 9'(wfr_cycles), 9'h0);
        check("toggle_evc", {5'h0, evc}, 9'h1);
        check("toggle_alarm", {8'h0, alarm}, 9'h1);

        // Overload held through rearm: timeout re-enters, third event locks out.
        clr = 1'b1;
        step(70, "rearm_timeout");
        check("lockout_set", {8'h0, lock}, 9'h1);
        check("lockout_evc", {5'h0, evc}, 9'h3);

        // Lockout exit rules.
        mc = 1'b1; step(1, "mc_exc_hi"); mc = 1'b0;
        check("lock_hold", {8'h0, lock}, 9'h1);
        exc = 1'b0; clr = 1'b0;
        step(4, "lock_settle");
        mc = 1'b1; step(1, "mc_exc_lo"); mc = 1'b0;
        check("lock_exit", {wfr, door, motion, alarm, lock, evc}, 9'h0);

        // Asynchronous reset in the middle of the pulse.
        exc = 1'b1; clr = 1'b1;
        wait_pulse("pulse_rst");
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_pulse", {wfr, door, motion, alarm, lock, evc}, 9'h0);
        step(2, "in_reset2");
        rst_n = 1'b1;
        step(2, "post_rst_early");
        check("no_early_move", {8'h0, door}, 9'h0);
        step(1, "post_rst_edge3");
        check("third_edge_move", {8'h0, door}, 9'h1);

        // Random activity.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(7) == 0) exc = ~exc;
            if ($urandom_range(5) == 0) clr = ~clr;
            mc = ($urandom_range(19) == 0);
            step(1, "random");
        end
        mc = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
